timer_chain_ctrl: RTL and testbench



---
 rtl/timer_chain_ctrl_if.sv | 38 +++
 rtl/timer_chain_ctrl.sv | 159 +++++++++++++++
 tb/tb_timer_chain_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_chain_ctrl_if.sv
// Bundle between the timer sequencer and its chain of BCD countdown digit cells.
//   master : digit-cell side (drives commands, digit values, borrow requests, timeouts)
//   slave  : sequencer side  (drives load strobe, decrements, no-borrow, status)
// Signals:
//   load_req, start, stop      timer commands
//   digits[4*N_DIGITS]         current digit values, digit k on [4k+3:4k]
//   borrow_req[N_DIGITS]       borrow request from each digit cell
//   tout[N_DIGITS]             timeout flag from each digit cell
//   inp_load                   load strobe to all digit cells
//   dec[N_DIGITS]              decrement strobe to each digit cell
//   no_borrow[N_DIGITS]        no-borrow qualifier to each digit cell
//   running, done, expired     timer status
interface timer_chain_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load_req;
  logic                    start;
  logic                    stop;
  logic [4*N_DIGITS-1:0]   digits;
  logic [N_DIGITS-1:0]     borrow_req;
  logic [N_DIGITS-1:0]     tout;
  logic                    inp_load;
  logic [N_DIGITS-1:0]     dec;
  logic [N_DIGITS-1:0]     no_borrow;
  logic                    running;
  logic                    done;
  logic                    expired;

  modport master (
    output load_req, start, stop, digits, borrow_req, tout,
    input  inp_load, dec, no_borrow, running, done, expired
  );

  modport slave (
    input  load_req, start, stop, digits, borrow_req, tout,
    output inp_load, dec, no_borrow, running, done, expired
  );
endinterface

// File: rtl/timer_chain_ctrl.sv
// Sequencer for a chain of BCD countdown digit cells.
// Generates the base decrement tick for digit 0, routes each digit's borrow
// request to the next-higher digit, computes no-borrow qualifiers and runs the
// IDLE/LOAD/RUN/PAUSE/DONE control for the whole timer.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous reset, active-low
//   tc_io  slave side of timer_chain_ctrl_if (commands, digit status in;
//          load/decrement/no-borrow/status out)
// N_DIGITS must be at least 2.
module timer_chain_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned CNT_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  timer_chain_ctrl_if.slave tc_io
);

  localparam int unsigned      DIG_W      = 4;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             inp_load_q, inp_load_d;
  logic             dec0_q, dec0_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  logic                all_zero;
  logic [N_DIGITS-1:0] dec_w;
  logic [N_DIGITS-1:0] no_borrow_w;
  logic                in_unused;

  // Only tout[0] qualifies expiry; the top digit's borrow has nowhere to go.
  assign in_unused = ^{tc_io.tout[N_DIGITS-1:1], tc_io.borrow_req[N_DIGITS-1]};

  assign all_zero = (tc_io.digits == '0);

  // State, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      inp_load_q <= 1'b0;
      dec0_q     <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      inp_load_q <= inp_load_d;
      dec0_q     <= dec0_d;
      running_q  <= running_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
    end
  end

  // Next state, prescaler and output decode; priority load_req > start > stop.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dec0_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tc_io.load_req) begin
          state_d = S_LOAD;
        end else if (tc_io.start) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (tc_io.load_req) begin
          state_d = S_LOAD;
        end else if (all_zero && tc_io.tout[0]) begin
          state_d = S_DONE;
        end else if (tc_io.stop && !tc_io.start) begin
          state_d = S_PAUSE;
        end
        // The prescaler only advances on cycles that stay in RUN, so a stop
        // freezes it at the value it had when the stop was seen.
        if (state_d == S_RUN) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dec0_d  = 1'b1;
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (tc_io.load_req) begin
          state_d = S_LOAD;
        end else if (tc_io.start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (tc_io.load_req) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    inp_load_d = (state_d == S_LOAD);
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    expired_d  = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // Borrow routing: a borrow request from digit k-1 decrements digit k, and
  // keeps rippling through PAUSE and DONE so a pending borrow is never lost.
  always_comb begin
    dec_w    = '0;
    dec_w[0] = dec0_q;
    if (state_q inside {S_RUN, S_PAUSE, S_DONE}) begin
      dec_w[N_DIGITS-1:1] = tc_io.borrow_req[N_DIGITS-2:0];
    end
  end

  // No-borrow for digit k is set when every higher digit is zero.
  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    no_borrow_w = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      no_borrow_w[k] = upper_zero;
      upper_zero     = upper_zero & (tc_io.digits[DIG_W*k +: DIG_W] == 4'd0);
    end
  end

  assign tc_io.inp_load  = inp_load_q;
  assign tc_io.dec       = dec_w;
  assign tc_io.no_borrow = no_borrow_w;
  assign tc_io.running   = running_q;
  assign tc_io.done      = done_q;
  assign tc_io.expired   = expired_q;

endmodule

// File: tb/tb_timer_chain_ctrl.sv
// Bench for timer_chain_ctrl: behavioural BCD digit cells close the loop,
// expected tick/expiry cycles are queued when stimulus is applied and popped
// by a monitor when the controller produces them.
module tb_timer_chain_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;

  timer_chain_ctrl_if #(.N_DIGITS(N)) tc ();

  timer_chain_ctrl #(
    .N_DIGITS (N),
    .TICK_DIV (TD),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tc_io (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- digit cell models ----------------
  logic [3:0]     cell_d [N];
  logic [N-1:0]   cell_br;
  logic [4*N-1:0] load_val;
  logic           cells_clr;

  always @(posedge clk) begin
    cell_br <= '0;
    for (int k = 0; k < N; k++) begin
      if (cells_clr) begin
        cell_d[k] <= 4'd0;
      end else if (tc.inp_load) begin
        cell_d[k] <= load_val[4*k +: 4];
      end else if (tc.dec[k]) begin
        if (cell_d[k] != 4'd0) begin
          cell_d[k] <= cell_d[k] - 4'd1;
        end else if (!tc.no_borrow[k]) begin
          cell_d[k]  <= 4'd9;
          cell_br[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      tc.digits[4*k +: 4] = cell_d[k];
      tc.tout[k]          = (cell_d[k] == 4'd0) && tc.no_borrow[k];
    end
  end
  assign tc.borrow_req = cell_br;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  int tick_q[$];
  int exp_q[$];
  logic exp_prev = 1'b0;

  // Monitor: every dec[0] pulse and expired pulse must match a queued cycle.
  always @(negedge clk) begin
    if (tc.dec[0]) begin
      if (tick_q.size() == 0) chk("dec0_spurious", 32'(tc.dec[0]), 32'd0);
      else                    chk("dec0_cycle", 32'(cyc), 32'(tick_q.pop_front()));
    end
    if (tc.expired) begin
      if (exp_q.size() == 0) chk("expired_spurious", 32'(tc.expired), 32'd0);
      else                   chk("expired_cycle", 32'(cyc), 32'(exp_q.pop_front()));
    end
    if (exp_prev) chk("expired_width", 32'(tc.expired), 32'd0);
    exp_prev = tc.expired;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] val);
    load_val    = val;
    tc.load_req = 1'b1;
    @(negedge clk);
    tc.load_req = 1'b0;
    chk("load_strobe", 32'(tc.inp_load), 32'd1);
    @(negedge clk);
    chk("load_strobe_end", 32'(tc.inp_load), 32'd0);
    chk("load_digits", 32'(tc.digits), 32'(val));
  endtask

  task automatic do_start(input logic with_stop, output int s);
    s        = cyc;
    tc.start = 1'b1;
    tc.stop  = with_stop;
    @(negedge clk);
    tc.start = 1'b0;
    tc.stop  = 1'b0;
  endtask

  task automatic push_ticks(input int first, input int n);
    for (int i = 0; i < n; i++) tick_q.push_back(first + TD * i);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_ticks_left"}, 32'(tick_q.size()), 32'd0);
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Global bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p, s2, held, first, last;
    rst         = 1'b0;
    cells_clr   = 1'b1;
    load_val    = '0;
    tc.load_req = 1'b0;
    tc.start    = 1'b0;
    tc.stop     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_inp_load", 32'(tc.inp_load), 32'd0);
    chk("rst_dec", 32'(tc.dec), 32'd0);
    chk("rst_running", 32'(tc.running), 32'd0);
    chk("rst_done", 32'(tc.done), 32'd0);
    chk("rst_expired", 32'(tc.expired), 32'd0);
    chk("rst_no_borrow", 32'(tc.no_borrow), 32'hF);
    rst       = 1'b1;
    cells_clr = 1'b0;
    @(negedge clk);

    // stop is ignored in IDLE.
    tc.stop = 1'b1;
    @(negedge clk);
    tc.stop = 1'b0;
    chk("idle_stop_running", 32'(tc.running), 32'd0);

    // 1: count 12 down to expiry; start+stop together from IDLE starts.
    do_load(16'h0012);
    do_start(1'b1, s);
    chk("t1_running", 32'(tc.running), 32'd1);
    push_ticks(s + 1 + TD, 12);
    exp_q.push_back(s + 1 + TD * 12 + 2);
    wait_until(s + 1 + TD * 12);
    wait_until(s + 1 + TD * 12 + 5);
    chk("t1_done", 32'(tc.done), 32'd1);
    chk("t1_running_end", 32'(tc.running), 32'd0);
    chk("t1_digits", 32'(tc.digits), 32'h0000);
    chk_drained("t1");

    // 2: ripple borrow from 100 to 099.
    do_load(16'h0100);
    do_start(1'b0, s);
    push_ticks(s + 1 + TD, 1);
    wait_until(s + 2 + TD);
    chk("t2_dec1", 32'(tc.dec), 32'b0010);
    wait_until(s + 3 + TD);
    chk("t2_dec2", 32'(tc.dec), 32'b0100);
    wait_until(s + 4 + TD);
    chk("t2_digits", 32'(tc.digits), 32'h0099);
    chk("t2_no_borrow", 32'(tc.no_borrow), 32'b1110);
    // load_req aborts the run, loading 30 for the next test.
    do_load(16'h0030);
    chk("t2_abort_running", 32'(tc.running), 32'd0);
    chk_drained("t2");

    // 3: pause after two ticks, resume with start+stop together.
    do_start(1'b0, s);
    push_ticks(s + 1 + TD, 2);
    wait_until(s + 2 * TD + 2);
    tc.stop = 1'b1;
    @(negedge clk);
    tc.stop = 1'b0;
    chk("t3_pause_running", 32'(tc.running), 32'd0);
    chk("t3_pause_digits", 32'(tc.digits), 32'h0028);
    repeat (20) @(negedge clk);
    chk("t3_hold_digits", 32'(tc.digits), 32'h0028);
    chk("t3_hold_ticks", 32'(tick_q.size()), 32'd0);
    held = (2 * TD + 2 - 1) % TD;
    do_start(1'b1, p);
    first = p + 1 + (TD - held);
    last  = first + TD * 27;
    push_ticks(first, 28);
    exp_q.push_back(last + 2);
    wait_until(last + 5);
    chk("t3_done", 32'(tc.done), 32'd1);
    chk_drained("t3");

    // 4: start with all digits zero expires with no tick.
    do_load(16'h0000);
    do_start(1'b0, s);
    exp_q.push_back(s + 2);
    wait_until(s + 5);
    chk("t4_done", 32'(tc.done), 32'd1);
    chk("t4_dec", 32'(tc.dec), 32'd0);
    chk_drained("t4");

    // 5: reset mid-run, then restart from a cleared prescaler.
    do_load(16'h0057);
    do_start(1'b0, s);
    push_ticks(s + 1 + TD, 2);
    wait_until(s + 2 * TD + 2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_running", 32'(tc.running), 32'd0);
    chk("t5_done", 32'(tc.done), 32'd0);
    chk("t5_dec", 32'(tc.dec), 32'd0);
    chk("t5_digits", 32'(tc.digits), 32'h0055);
    @(negedge clk);
    do_start(1'b0, s2);
    push_ticks(s2 + 1 + TD, 1);
    wait_until(s2 + 2 + TD);
    chk("t5_digits_after", 32'(tc.digits), 32'h0054);

    // 6: load_req with start and stop mid-run takes LOAD.
    load_val    = 16'h0042;
    tc.load_req = 1'b1;
    tc.start    = 1'b1;
    tc.stop     = 1'b1;
    @(negedge clk);
    tc.load_req = 1'b0;
    tc.start    = 1'b0;
    tc.stop     = 1'b0;
    chk("t6_inp_load", 32'(tc.inp_load), 32'd1);
    chk("t6_running_load", 32'(tc.running), 32'd0);
    @(negedge clk);
    chk("t6_inp_load_end", 32'(tc.inp_load), 32'd0);
    chk("t6_running", 32'(tc.running), 32'd0);
    chk("t6_digits", 32'(tc.digits), 32'h0042);
    repeat (2 * TD) @(negedge clk);
    chk("t6_idle_running", 32'(tc.running), 32'd0);
    chk_drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
